// File: rtl/timer_ctrl_if.sv
// Command channel between a host/sequencer and the interval-timer controller.
// Valid/ready handshake carrying opcode plus START-time limit and reload mode.
interface timer_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_limit;
  logic             cmd_auto;

  modport master (
    output cmd_valid, cmd_op, cmd_limit, cmd_auto,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_limit, cmd_auto,
    output cmd_ready
  );
endinterface

// File: rtl/timer_ctrl.sv
// Programmable interval-timer controller: start/pause/resume/abort sequencing
// around a WIDTH-bit tick counter with one-shot or auto-reload expiry.
module timer_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  timer_ctrl_if.slave      cmd,
  input  logic             tick_en_i,
  output logic [WIDTH-1:0] count_o,
  output logic [1:0]       state_o,
  output logic             expire_o,
  output logic [WIDTH-1:0] periods_o,
  output logic             cmd_err_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_DONE   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OP_START  = 2'b00,
    OP_PAUSE  = 2'b01,
    OP_RESUME = 2'b10,
    OP_ABORT  = 2'b11
  } op_e;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] count_q,   count_d;
  logic [WIDTH-1:0] periods_q, periods_d;
  logic [WIDTH-1:0] limit_q,   limit_d;
  logic             auto_q,    auto_d;
  logic             ready_q,   ready_d;
  logic             expire_q,  expire_d;
  logic             err_q,     err_d;
  logic             accept;

  assign accept = cmd.cmd_valid && ready_q;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      periods_q <= '0;
      limit_q   <= '0;
      auto_q    <= 1'b0;
      ready_q   <= 1'b1;
      expire_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      periods_q <= periods_d;
      limit_q   <= limit_d;
      auto_q    <= auto_d;
      ready_q   <= ready_d;
      expire_q  <= expire_d;
      err_q     <= err_d;
    end
  end

  // Next state: an accepted command always pre-empts a same-cycle tick.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    periods_d = periods_q;
    limit_d   = limit_q;
    auto_d    = auto_q;
    ready_d   = 1'b1;
    expire_d  = 1'b0;
    err_d     = 1'b0;

    if (accept) begin
      ready_d = 1'b0;
      unique case (op_e'(cmd.cmd_op))
        OP_START: begin
          limit_d   = cmd.cmd_limit;
          auto_d    = cmd.cmd_auto;
          count_d   = '0;
          periods_d = '0;
          state_d   = S_RUN;
        end
        OP_PAUSE: begin
          if (state_q == S_RUN) state_d = S_PAUSED;
          else                  err_d   = 1'b1;
        end
        OP_RESUME: begin
          if (state_q == S_PAUSED) state_d = S_RUN;
          else                     err_d   = 1'b1;
        end
        OP_ABORT: begin
          count_d   = '0;
          periods_d = '0;
          state_d   = S_IDLE;
        end
        default: ;
      endcase
    end else if (state_q == S_RUN && tick_en_i) begin
      if (count_q == limit_q) begin
        expire_d = 1'b1;
        if (auto_q) begin
          count_d = '0;
          if (periods_q != {WIDTH{1'b1}}) periods_d = periods_q + WIDTH'(1);
        end else begin
          state_d = S_DONE;
        end
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign count_o       = count_q;
  assign state_o       = state_q;
  assign expire_o      = expire_q;
  assign periods_o     = periods_q;
  assign cmd_err_o     = err_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed scoreboard bench for timer_ctrl: the driver queues the expected
// output snapshot for a given cycle, a negedge monitor pops and compares.
module tb_timer_ctrl;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_PAUSE  = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_ABORT  = 2'b11;
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_PAUSED = 2'b10;
  localparam logic [1:0] ST_DONE   = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_en;
  logic [7:0] count;
  logic [1:0] state;
  logic       expire;
  logic [7:0] periods;
  logic       cmd_err;

  timer_ctrl_if #(.WIDTH(8)) bus ();

  timer_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (bus),
    .tick_en_i (tick_en),
    .count_o   (count),
    .state_o   (state),
    .expire_o  (expire),
    .periods_o (periods),
    .cmd_err_o (cmd_err)
  );

  always #5 clk = ~clk;

  // Snapshot layout: count, state, expire, periods, cmd_err, cmd_ready.
  typedef struct {
    int          cyc;
    string       nm;
    logic [20:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t        e;
      logic [20:0] got;
      e   = sb.pop_front();
      got = {count, state, expire, periods, cmd_err, bus.cmd_ready};
      total++;
      if (e.cyc < cyc) begin
        bad++;
        $display("FAIL %s: expected at cycle %0d but checked at %0d", e.nm, e.cyc, cyc);
      end else if (got !== e.v) begin
        bad++;
        $display("FAIL %s cyc=%0d: got cnt=%0d st=%0d exp=%0d per=%0d err=%0d rdy=%0d, need cnt=%0d st=%0d exp=%0d per=%0d err=%0d rdy=%0d",
                 e.nm, cyc, got[20:13], got[12:11], got[10], got[9:2], got[1], got[0],
                 e.v[20:13], e.v[12:11], e.v[10], e.v[9:2], e.v[1], e.v[0]);
      end
    end
  end

  task automatic push_exp(input int c, input string nm, input logic [7:0] ec,
                          input logic [1:0] es, input logic ee, input logic [7:0] ep,
                          input logic er, input logic ey);
    exp_t e;
    e.cyc = c;
    e.nm  = nm;
    e.v   = {ec, es, ee, ep, er, ey};
    sb.push_back(e);
  endtask

  // Entered at posedge+1: drive one cycle of inputs and queue the next-cycle result.
  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] lim,
                       input logic au, input logic tk, input string nm,
                       input logic [7:0] ec, input logic [1:0] es, input logic ee,
                       input logic [7:0] ep, input logic er, input logic ey);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_limit = lim;
    bus.cmd_auto  = au;
    tick_en       = tk;
    push_exp(cyc + 1, nm, ec, es, ee, ep, er, ey);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    int base;
    rst_n         = 1'b0;
    tick_en       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_START;
    bus.cmd_limit = 8'd0;
    bus.cmd_auto  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push_exp(cyc, "reset", 8'd0, ST_IDLE, 1'b0, 8'd0, 1'b0, 1'b1);
    rst_n = 1'b1;

    // One-shot limit 3; the START-cycle tick is discarded.
    drive(1, OP_START, 8'd3, 0, 1, "os_start", 8'd0, ST_RUN, 0, 8'd0, 0, 0);
    drive(0, OP_START, 8'd0, 0, 1, "os_c1",    8'd1, ST_RUN, 0, 8'd0, 0, 1);
    drive(0, OP_START, 8'd0, 0, 1, "os_c2",    8'd2, ST_RUN, 0, 8'd0, 0, 1);
    drive(0, OP_START, 8'd0, 0, 1, "os_c3",    8'd3, ST_RUN, 0, 8'd0, 0, 1);
    drive(0, OP_START, 8'd0, 0, 1, "os_exp",   8'd3, ST_DONE, 1, 8'd0, 0, 1);
    drive(0, OP_START, 8'd0, 0, 1, "os_hold1", 8'd3, ST_DONE, 0, 8'd0, 0, 1);
    drive(0, OP_START, 8'd0, 0, 1, "os_hold2", 8'd3, ST_DONE, 0, 8'd0, 0, 1);
    drive(1, OP_ABORT, 8'd0, 0, 0, "abort",    8'd0, ST_IDLE, 0, 8'd0, 0, 0);
    drive(0, OP_START, 8'd0, 0, 0, "abort_r",  8'd0, ST_IDLE, 0, 8'd0, 0, 1);

    // Illegal PAUSE in IDLE.
    drive(1, OP_PAUSE, 8'd0, 0, 1, "pause_idle", 8'd0, ST_IDLE, 0, 8'd0, 1, 0);
    drive(0, OP_START, 8'd0, 0, 1, "err_clr",    8'd0, ST_IDLE, 0, 8'd0, 0, 1);

    // Auto limit 2: expire every 3 cycles.
    drive(1, OP_START, 8'd2, 1, 0, "auto_start", 8'd0, ST_RUN, 0, 8'd0, 0, 0);
    for (int i = 0; i < 9; i++)
      drive(0, OP_START, 8'd0, 0, 1, $sformatf("auto_%0d", i), 8'((i + 1) % 3), ST_RUN,
            (i % 3) == 2, 8'((i + 1) / 3), 0, 1);

    // Pause at 5, hold through ticks, resume.
    drive(1, OP_START, 8'd10, 0, 0, "pr_start", 8'd0, ST_RUN, 0, 8'd0, 0, 0);
    for (int i = 1; i <= 5; i++)
      drive(0, OP_START, 8'd0, 0, 1, $sformatf("pr_c%0d", i), 8'(i), ST_RUN, 0, 8'd0, 0, 1);
    drive(1, OP_PAUSE, 8'd0, 0, 1, "pr_pause", 8'd5, ST_PAUSED, 0, 8'd0, 0, 0);
    for (int i = 0; i < 10; i++)
      drive(0, OP_START, 8'd0, 0, 1, $sformatf("pr_hold%0d", i), 8'd5, ST_PAUSED, 0, 8'd0, 0, 1);
    drive(1, OP_RESUME, 8'd0, 0, 0, "pr_resume", 8'd5, ST_RUN, 0, 8'd0, 0, 0);
    drive(0, OP_START,  8'd0, 0, 1, "pr_c6",     8'd6, ST_RUN, 0, 8'd0, 0, 1);
    drive(1, OP_RESUME, 8'd0, 0, 0, "resume_run", 8'd6, ST_RUN, 0, 8'd0, 1, 0);
    drive(0, OP_START,  8'd0, 0, 0, "rr_clr",     8'd6, ST_RUN, 0, 8'd0, 0, 1);

    // PAUSE collides with the expiring tick at limit 4.
    drive(1, OP_START, 8'd4, 0, 0, "col_start", 8'd0, ST_RUN, 0, 8'd0, 0, 0);
    for (int i = 1; i <= 4; i++)
      drive(0, OP_START, 8'd0, 0, 1, $sformatf("col_c%0d", i), 8'(i), ST_RUN, 0, 8'd0, 0, 1);
    drive(1, OP_PAUSE,  8'd0, 0, 1, "col_pause",  8'd4, ST_PAUSED, 0, 8'd0, 0, 0);
    drive(0, OP_START,  8'd0, 0, 1, "col_hold",   8'd4, ST_PAUSED, 0, 8'd0, 0, 1);
    drive(1, OP_RESUME, 8'd0, 0, 0, "col_resume", 8'd4, ST_RUN, 0, 8'd0, 0, 0);
    drive(0, OP_START,  8'd0, 0, 1, "col_exp",    8'd4, ST_DONE, 1, 8'd0, 0, 1);
    drive(1, OP_RESUME, 8'd0, 0, 1, "resume_done", 8'd4, ST_DONE, 0, 8'd0, 1, 0);
    drive(0, OP_START,  8'd0, 0, 1, "rd_clr",     8'd4, ST_DONE, 0, 8'd0, 0, 1);

    // Limit 0 in both modes.
    drive(1, OP_START, 8'd0, 1, 0, "z_auto", 8'd0, ST_RUN, 0, 8'd0, 0, 0);
    for (int i = 1; i <= 3; i++)
      drive(0, OP_START, 8'd0, 0, 1, $sformatf("z_auto%0d", i), 8'd0, ST_RUN, 1, 8'(i), 0, 1);
    drive(1, OP_START, 8'd0, 0, 0, "z_os",      8'd0, ST_RUN, 0, 8'd0, 0, 0);
    drive(0, OP_START, 8'd0, 0, 1, "z_os_exp",  8'd0, ST_DONE, 1, 8'd0, 0, 1);
    drive(0, OP_START, 8'd0, 0, 1, "z_os_hold", 8'd0, ST_DONE, 0, 8'd0, 0, 1);

    // Auto limit 7 up to count 7 with two periods, then a short async reset pulse.
    drive(1, OP_START, 8'd7, 1, 0, "rst_start", 8'd0, ST_RUN, 0, 8'd0, 0, 0);
    for (int i = 0; i < 23; i++)
      drive(0, OP_START, 8'd0, 0, 1, $sformatf("rst_t%0d", i), 8'((i + 1) % 8), ST_RUN,
            (i % 8) == 7, 8'((i + 1) / 8), 0, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    push_exp(cyc + 1, "async_rst", 8'd0, ST_IDLE, 0, 8'd0, 0, 1);
    @(posedge clk);
    #1;

    // Periods saturation with limit 255.
    drive(1, OP_START, 8'd255, 1, 0, "sat_start", 8'd0, ST_RUN, 0, 8'd0, 0, 0);
    tick_en = 1'b1;
    base    = cyc;
    push_exp(base + 255,         "sat_c255", 8'd255, ST_RUN, 0, 8'd0,   0, 1);
    push_exp(base + 256,         "sat_p1",   8'd0,   ST_RUN, 1, 8'd1,   0, 1);
    push_exp(base + 255 * 256,   "sat_p255", 8'd0,   ST_RUN, 1, 8'd255, 0, 1);
    push_exp(base + 256 * 256,   "sat_hold", 8'd0,   ST_RUN, 1, 8'd255, 0, 1);
    push_exp(base + 256 * 256 + 1, "sat_c1", 8'd1,   ST_RUN, 0, 8'd255, 0, 1);
    repeat (256 * 256 + 1) @(posedge clk);
    #1 tick_en = 1'b0;

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations never checked, need 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
